sprite_update_ctrl: RTL and testbench

SPRITE_UPDATE_CTRL -- requirements
Module: sprite_update_ctrl

---
 rtl/sprite_update_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_sprite_update_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_update_ctrl.sv
// ============================================================================
// sprite_update_ctrl
//
// Purpose:
//   Buffers host writes to a sprite's position and attribute registers and
//   replays them only during vertical blanking, so the sprite never changes
//   mid-frame. Writes land in a small FIFO during active video. At the start
//   of each vblank the controller snapshots how many entries are waiting and
//   issues exactly that many, one per cycle, as a payload plus a load strobe.
//
// Parameters:
//   FIFO_DEPTH  number of pending write entries (power of two, 2..16)
//   V_ACTIVE    first pixel_y value that belongs to vertical blanking
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   rst         asynchronous reset, active low
//   pixel_y     current scan line from the VGA timing generator
//   wr_en       host write strobe, one entry per cycle while high
//   wr_sel      entry type: 0 = position, 1 = attribute
//   wr_data     entry payload
//   wr_full     FIFO holds FIFO_DEPTH entries
//   wr_ovf      one-cycle pulse after a write was dropped because of full
//   data_out    payload presented to the sprite data input
//   load_pos    one-cycle load strobe for the sprite position register
//   load_att    one-cycle load strobe for the sprite attribute register
//   frame_tick  one-cycle pulse at the start of vblank
//   busy        high while entries are being drained
// ============================================================================
module sprite_update_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int V_ACTIVE   = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  pixel_y,
    input  logic        wr_en,
    input  logic        wr_sel,
    input  logic [31:0] wr_data,
    output logic        wr_full,
    output logic        wr_ovf,
    output logic [31:0] data_out,
    output logic        load_pos,
    output logic        load_att,
    output logic        frame_tick,
    output logic        busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [9:0]       V_ACTIVE_Y = 10'(V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic             vblank;
    logic             vblank_d;
    logic             vblank_rise;

    logic [32:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] pending;
    logic [32:0]      head;

    logic             push;
    logic             pop;
    logic             snapshot;

    // ------------------------------------------------------------------
    // Vertical blanking detection
    // ------------------------------------------------------------------
    assign vblank      = (pixel_y >= V_ACTIVE_Y);
    assign vblank_rise = vblank & ~vblank_d;

    // vblank_d comes out of reset high so that releasing reset in the middle
    // of a blanking interval is not mistaken for the start of one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vblank_d   <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vblank_d   <= vblank;
            frame_tick <= vblank_rise;
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    // A full FIFO still accepts a write when an entry leaves in the same
    // cycle, since the slot being read is the one the write pointer reuses.
    assign push    = wr_en & ((count != DEPTH_C) | pop);
    assign wr_full = (count == DEPTH_C);
    assign head    = mem[rd_ptr];

    // Storage has no reset; emptiness is carried entirely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {wr_sel, wr_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            wr_ovf <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            wr_ovf <= wr_en & ~push;
        end
    end

    // ------------------------------------------------------------------
    // Frame budget: the number of entries owed to the current vblank.
    // Taken from count before any same-cycle push, so later writes wait
    // for the next frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else if (snapshot) begin
            pending <= count;
        end else if (pop) begin
            pending <= pending - CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic. HOLD parks the controller for the rest of the
    // blanking interval so a frame is drained at most once.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (vblank_rise) begin
                    state_next = (count != '0) ? DRAIN : HOLD;
                end
            end
            DRAIN: begin
                if (!vblank) begin
                    state_next = IDLE;
                end else if (pending <= CNT_W'(1)) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!vblank) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs. Popping stops the same cycle vblank falls, leaving the
    // remaining entries queued in order for the next frame.
    // ------------------------------------------------------------------
    always_comb begin
        snapshot = 1'b0;
        pop      = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE: begin
                snapshot = vblank_rise;
            end
            DRAIN: begin
                busy = 1'b1;
                pop  = vblank & (pending != '0);
            end
            default: begin
                snapshot = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Issue stage: present the popped payload and strobe the matching
    // sprite register one cycle after the pop. data_out holds otherwise.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
            load_pos <= 1'b0;
            load_att <= 1'b0;
        end else begin
            load_pos <= pop & ~head[32];
            load_att <= pop &  head[32];
            if (pop) begin
                data_out <= head[31:0];
            end
        end
    end

endmodule

// File: tb/tb_sprite_update_ctrl.sv
// ============================================================================
// tb_sprite_update_ctrl
//
// Purpose:
//   Self-checking bench for sprite_update_ctrl. A queue-based model tracks
//   the pending writes and how many entries the current blanking interval
//   still owes; a per-cycle compare checks every DUT output against it.
//   Directed scenarios add hand-computed expectations on top.
// ============================================================================
module tb_sprite_update_ctrl;

    localparam int DEPTH = 4;
    localparam int VACT  = 480;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  pixel_y = '0;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_full;
    logic        wr_ovf;
    logic [31:0] data_out;
    logic        load_pos;
    logic        load_att;
    logic        frame_tick;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    sprite_update_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .V_ACTIVE   (VACT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pixel_y    (pixel_y),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .wr_full    (wr_full),
        .wr_ovf     (wr_ovf),
        .data_out   (data_out),
        .load_pos   (load_pos),
        .load_att   (load_att),
        .frame_tick (frame_tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a queue of {sel, data}, the previous vblank sample,
    // and the number of entries this blanking interval still owes.
    // ------------------------------------------------------------------
    logic [32:0] mq[$];
    logic        m_vprev = 1'b1;
    int          m_owed = 0;
    logic        m_vb;
    logic        m_rise;
    logic        m_popped;
    logic [32:0] m_ent;
    logic [31:0] e_data = '0;
    logic        e_pos = 1'b0;
    logic        e_att = 1'b0;
    logic        e_ovf = 1'b0;
    logic        e_tick = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_vprev = 1'b1;
            m_owed  = 0;
            e_data  = '0;
            e_pos   = 1'b0;
            e_att   = 1'b0;
            e_ovf   = 1'b0;
            e_tick  = 1'b0;
        end else begin
            m_vb     = (pixel_y >= VACT);
            m_rise   = m_vb && !m_vprev;
            m_popped = 1'b0;
            e_pos    = 1'b0;
            e_att    = 1'b0;
            if (!m_vb) begin
                m_owed = 0;
            end else if (m_rise) begin
                m_owed = mq.size();
            end else if (m_owed > 0) begin
                m_ent    = mq.pop_front();
                m_popped = 1'b1;
                m_owed   = m_owed - 1;
                e_data   = m_ent[31:0];
                e_pos    = !m_ent[32];
                e_att    = m_ent[32];
            end
            // Size is already post-pop, so a full queue freed this cycle accepts.
            if (wr_en && mq.size() < DEPTH) begin
                mq.push_back({wr_sel, wr_data});
                e_ovf = 1'b0;
            end else begin
                e_ovf = wr_en;
            end
            e_tick  = m_rise;
            m_vprev = m_vb;
        end
    end

    // ------------------------------------------------------------------
    // Comparison helper shared by the per-cycle compare and directed checks
    // ------------------------------------------------------------------
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Per-cycle compare, issued-entry log and frame_tick counter
    // ------------------------------------------------------------------
    logic [32:0] issued[$];
    int          tick_cnt = 0;

    always @(negedge clk) begin
        checkOutput("cycle", {25'd0, wr_full, wr_ovf, data_out, load_pos, load_att, frame_tick, busy},
                    {25'd0, (mq.size() == DEPTH), e_ovf, e_data, e_pos, e_att, e_tick, (m_owed > 0)});
        if (load_pos || load_att) issued.push_back({load_att, data_out});
        if (frame_tick) tick_cnt++;
    end

    // Drive one cycle of inputs at a falling edge, return at the next one.
    task automatic applyStimulus(input logic [9:0] py, input logic en, input logic sel,
                                 input logic [31:0] d);
        pixel_y = py;
        wr_en   = en;
        wr_sel  = sel;
        wr_data = d;
        @(negedge clk);
    endtask

    int saved_log;
    int saved_ticks;

    initial begin
        #3 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", {wr_full, wr_ovf, data_out, load_pos, load_att, frame_tick, busy}, '0);
        #2 rst = 1'b1;
        @(negedge clk);

        // Basic position then attribute update across one vblank
        applyStimulus(100, 1, 0, 32'h0001_0002);
        applyStimulus(100, 1, 1, 32'h0000_00FF);
        checkOutput("t1_not_full", wr_full, 0);
        applyStimulus(479, 0, 0, 0);
        applyStimulus(480, 0, 0, 0);
        checkOutput("t1_tick", frame_tick, 1);
        checkOutput("t1_busy_a", busy, 1);
        checkOutput("t1_no_load_yet", load_pos, 0);
        applyStimulus(480, 0, 0, 0);
        checkOutput("t1_load_pos", load_pos, 1);
        checkOutput("t1_data_pos", data_out, 32'h0001_0002);
        checkOutput("t1_tick_once", frame_tick, 0);
        checkOutput("t1_busy_b", busy, 1);
        applyStimulus(480, 0, 0, 0);
        checkOutput("t1_load_att", {load_pos, load_att}, 2'b01);
        checkOutput("t1_data_att", data_out, 32'h0000_00FF);
        checkOutput("t1_busy_done", busy, 0);
        applyStimulus(480, 0, 0, 0);
        checkOutput("t1_data_hold", {load_att, data_out}, {1'b0, 32'h0000_00FF});
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);

        // Overflow: five writes into four slots
        issued.delete();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(100, 1, i[0], 32'(16 + i));
            if (i == 3) checkOutput("t2_full", {wr_full, wr_ovf}, 2'b10);
            if (i == 4) checkOutput("t2_ovf", wr_ovf, 1);
        end
        applyStimulus(100, 0, 0, 0);
        checkOutput("t2_ovf_one_cycle", {wr_full, wr_ovf}, 2'b10);
        applyStimulus(479, 0, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(480, 0, 0, 0);
        checkOutput("t2_count", issued.size(), 4);
        for (int i = 0; i < 4; i++) checkOutput("t2_entry", issued[i], {i[0], 32'(16 + i)});
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);

        // Write arriving during a drain waits for the next frame
        issued.delete();
        applyStimulus(100, 1, 0, 32'h20);
        applyStimulus(100, 1, 1, 32'h21);
        applyStimulus(479, 0, 0, 0);
        applyStimulus(480, 0, 0, 0);
        applyStimulus(480, 1, 1, 32'h22);
        for (int i = 0; i < 5; i++) applyStimulus(480, 0, 0, 0);
        checkOutput("t3_frame1_count", issued.size(), 2);
        checkOutput("t3_frame1_last", issued[1], {1'b1, 32'h21});
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(479, 0, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(480, 0, 0, 0);
        checkOutput("t3_frame2_count", issued.size(), 3);
        checkOutput("t3_late_entry", issued[2], {1'b1, 32'h22});
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0);

        // vblank ends after two pops
        issued.delete();
        for (int i = 0; i < 4; i++) applyStimulus(100, 1, i[0], 32'(48 + i));
        applyStimulus(479, 0, 0, 0);
        applyStimulus(480, 0, 0, 0);
        applyStimulus(480, 0, 0, 0);
        applyStimulus(480, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0);
        checkOutput("t4_cut_count", issued.size(), 2);
        checkOutput("t4_cut_idle", busy, 0);
        checkOutput("t4_cut_last", issued[1], {1'b1, 32'h31});
        applyStimulus(479, 0, 0, 0);
        for (int i = 0; i < 7; i++) applyStimulus(480, 0, 0, 0);
        checkOutput("t4_resume_count", issued.size(), 4);
        checkOutput("t4_resume_a", issued[2], {1'b0, 32'h32});
        checkOutput("t4_resume_b", issued[3], {1'b1, 32'h33});
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0);

        // Reset in the middle of a drain, released during vblank
        for (int i = 0; i < 3; i++) applyStimulus(100, 1, i[0], 32'(80 + i));
        applyStimulus(479, 0, 0, 0);
        applyStimulus(480, 0, 0, 0);
        applyStimulus(480, 0, 0, 0);
        pixel_y = 500;
        #2 rst = 1'b0;
        #1 checkOutput("t5_reset_outputs", {wr_full, wr_ovf, data_out, load_pos, load_att, frame_tick, busy}, '0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        saved_log   = issued.size();
        saved_ticks = tick_cnt;
        for (int i = 0; i < 5; i++) applyStimulus(500, 0, 0, 0);
        checkOutput("t5_no_strobes", issued.size(), saved_log);
        checkOutput("t5_no_tick", tick_cnt, saved_ticks);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(480, 0, 0, 0);
        checkOutput("t5_tick_after", tick_cnt, saved_ticks + 1);
        checkOutput("t5_queue_flushed", issued.size(), saved_log);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0);

        // Full FIFO: push and pop in the same cycle
        issued.delete();
        for (int i = 0; i < 4; i++) applyStimulus(100, 1, i[0], 32'(64 + i));
        checkOutput("t6_full", wr_full, 1);
        applyStimulus(479, 0, 0, 0);
        applyStimulus(480, 0, 0, 0);
        applyStimulus(480, 1, 1, 32'h44);
        checkOutput("t6_still_full", {wr_full, wr_ovf}, 2'b10);
        checkOutput("t6_first_pop", {load_pos, data_out}, {1'b1, 32'h40});
        for (int i = 0; i < 6; i++) applyStimulus(480, 0, 0, 0);
        checkOutput("t6_frame1_count", issued.size(), 4);
        checkOutput("t6_frame1_last", issued[3], {1'b1, 32'h43});
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(479, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(480, 0, 0, 0);
        checkOutput("t6_frame2_count", issued.size(), 5);
        checkOutput("t6_pushed_last", issued[4], {1'b1, 32'h44});
        checkOutput("t6_empty", wr_full, 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
